// File: rtl/pixel_write_sequencer_pkg.sv
// Shared definitions for the pixel write sequencer: grid geometry, pixel width and FSM encoding.
// RAM addresses are packed as {col,row}; the vga read side decodes them in the same order.
package pixel_write_sequencer_pkg;

  localparam int unsigned GRID_COLS = 128;
  localparam int unsigned GRID_ROWS = 64;
  localparam int unsigned PIX_W     = 12;

  localparam int unsigned COL_BITS = $clog2(GRID_COLS);
  localparam int unsigned ROW_BITS = $clog2(GRID_ROWS);

  typedef enum logic {
    StIdle = 1'b0,
    StScan = 1'b1
  } state_e;

endpackage

// File: rtl/pixel_write_sequencer_raster_counter.sv
// Column/row counter pair walking the block grid in raster order (column fastest).
module pixel_write_sequencer_raster_counter #(
  parameter int unsigned COL_W = 7,
  parameter int unsigned ROW_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             clear_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             last_o
);

  logic [COL_W-1:0] col_d, col_q;
  logic [ROW_W-1:0] row_d, row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
    end else if (inc_i) begin
      col_d = col_q + 1'b1;
      // Grid dimensions are powers of two, so the column wraps to 0 on its own.
      if (&col_q) begin
        row_d = row_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (&col_q) && (&row_q);

endmodule

// File: rtl/pixel_write_sequencer.sv
// Raster-order pixel sequencer: hands coordinates to the tracer, accepts colours over a
// valid/ready handshake and turns each accepted pixel into one registered RAM write.
module pixel_write_sequencer
  import pixel_write_sequencer_pkg::*;
#(
  parameter int unsigned COL_W      = COL_BITS,
  parameter int unsigned ROW_W      = ROW_BITS,
  parameter int unsigned DATA_W     = PIX_W,
  parameter bit          CONTINUOUS = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   pix_valid,
  input  logic [DATA_W-1:0]      pix_data,
  output logic                   pix_ready,
  output logic [COL_W-1:0]       col_addr,
  output logic [ROW_W-1:0]       row_addr,
  output logic                   wr_en,
  output logic [COL_W+ROW_W-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   busy,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt
);

  state_e state_d, state_q;

  logic                   accept;
  logic                   cnt_inc, cnt_clear, cnt_last;
  logic                   wr_en_d, wr_en_q;
  logic [COL_W+ROW_W-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0]      wr_data_d, wr_data_q;
  logic                   frame_done_d, frame_done_q;
  logic [7:0]             frame_cnt_d, frame_cnt_q;

  pixel_write_sequencer_raster_counter #(
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_raster_counter (
    .clk_i   (clk),
    .rst_ni  (rst),
    .inc_i   (cnt_inc),
    .clear_i (cnt_clear),
    .col_o   (col_addr),
    .row_o   (row_addr),
    .last_o  (cnt_last)
  );

  // Ready must not look at pix_valid, otherwise the tracer sees a combinational loop.
  assign pix_ready = (state_q == StScan) && !abort;
  assign accept    = pix_valid && pix_ready;

  always_comb begin
    state_d      = state_q;
    cnt_inc      = 1'b0;
    cnt_clear    = 1'b0;
    frame_done_d = 1'b0;
    frame_cnt_d  = frame_cnt_q;
    wr_en_d      = accept;
    wr_addr_d    = accept ? {col_addr, row_addr} : wr_addr_q;
    wr_data_d    = accept ? pix_data : wr_data_q;

    unique case (state_q)
      StIdle: begin
        if (start || CONTINUOUS) begin
          state_d   = StScan;
          cnt_clear = 1'b1;
        end
      end
      StScan: begin
        if (abort) begin
          state_d   = StIdle;
          cnt_clear = 1'b1;
        end else if (accept) begin
          if (cnt_last) begin
            state_d      = StIdle;
            cnt_clear    = 1'b1;
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign busy       = (state_q == StScan);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;

endmodule
